// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, controller states, round
// constants and the forward S-box table.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Entry 0 is unused (zero) so the table is indexed directly by round number.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        return (idx <= 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    // Byte 0 of the table sits in the most significant position.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX_TABLE[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: derives the next round key from the
// current one using four S-boxes and the word XOR chain.
module aes_key_round_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] work,
    input  logic [3:0]       rcnt,
    output logic [KEY_W-1:0] nxt
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot, sub, g;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign w0 = work[127:96];
    assign w1 = work[95:64];
    assign w2 = work[63:32];
    assign w3 = work[31:0];

    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[i*8 +: 8]),
            .y (sub[i*8 +: 8])
        );
    end

    assign g  = sub ^ {rcon_lookup(rcnt), 24'h0};
    assign n0 = w0 ^ g;
    assign n1 = n0 ^ w1;
    assign n2 = n1 ^ w2;
    assign n3 = n2 ^ w3;

    assign nxt = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = sbox_lookup(a);

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: expands one round per cycle into
// an 11-entry round-key buffer and serves it through a registered read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int KEY_W      = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t           state, state_next;
    logic [3:0]       rcnt;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] nxt;
    logic [KEY_W-1:0] key_buf [0:NUM_ROUNDS];
    logic             load;
    logic             step_en;
    logic             last_step;

    aes_key_round_step u_step (
        .work (work),
        .rcnt (rcnt),
        .nxt  (nxt)
    );

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                busy    = 1'b1;
                step_en = 1'b1;
                if (rcnt == LAST_ROUND) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign last_step = step_en && (rcnt == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rcnt       <= 4'd0;
            keys_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                rcnt       <= 4'd1;
                keys_valid <= 1'b0;
            end else if (last_step) begin
                rcnt       <= 4'd0;
                keys_valid <= 1'b1;
            end else if (step_en) begin
                rcnt <= rcnt + 4'd1;
            end
        end
    end

    // Key storage carries no reset; keys_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (load) begin
            key_buf[0] <= key_in;
            work       <= key_in;
        end else if (step_en) begin
            key_buf[rcnt] <= nxt;
            work          <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            if (keys_valid && (rd_round <= LAST_ROUND)) begin
                rd_key   <= key_buf[rd_round];
                rd_valid <= 1'b1;
                rd_err   <= 1'b0;
            end else begin
                rd_key   <= '0;
                rd_valid <= 1'b0;
                rd_err   <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl; the reference schedule is built
// from GF(2^8) arithmetic and the word-recurrence form of the key expansion.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;

    int total;
    int bad;

    logic [7:0]   ref_sbox [0:255];
    logic [127:0] model_rk [0:10];

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
                rc = 8'h01;
                for (int k = 1; k < i / 4; k++) rc = xt(rc);
                t = t ^ {rc, 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_key(input logic [127:0] key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic read_round(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({key_ready, busy, keys_valid, rd_valid, rd_err} !== 5'b10000 || rd_key !== 128'h0) begin
            bad++;
            $display("FAIL reset: ready/busy/kv/rv/re=%b rd_key=%h exp 10000 and 0",
                     {key_ready, busy, keys_valid, rd_valid, rd_err}, rd_key);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        logic [127:0] key;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        accept_key(key);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            total++;
            if (busy !== 1'b1 || keys_valid !== 1'b0 || key_ready !== 1'b0) begin
                bad++;
                $display("FAIL fips_expand_flags cyc=%0d: busy=%b kv=%b ready=%b exp 1 0 0",
                         cyc, busy, keys_valid, key_ready);
            end
            tick();
        end
        total++;
        if (keys_valid !== 1'b1 || busy !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL fips_done_flags: kv=%b busy=%b ready=%b exp 1 0 1",
                     keys_valid, busy, key_ready);
        end
        read_round(4'd1);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++;
            $display("FAIL fips_round1: valid=%b key=%h exp 1 a0fafe1788542cb123a339392a6c7605",
                     rd_valid, rd_key);
        end
        read_round(4'd10);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL fips_round10: valid=%b key=%h exp 1 d014f9a8c9ee2589e13f0cc8b6630ca6",
                     rd_valid, rd_key);
        end
        read_round(4'd0);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== key) begin
            bad++;
            $display("FAIL fips_round0: valid=%b key=%h exp 1 %h", rd_valid, rd_key, key);
        end
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== key) begin
            bad++;
            $display("FAIL idle_hold: valid=%b err=%b key=%h exp 0 0 %h", rd_valid, rd_err, rd_key, key);
        end
    endtask

    task automatic test_zero_key();
        accept_key(128'h0);
        for (int cyc = 1; cyc <= 10; cyc++) tick();
        read_round(4'd1);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== 128'h62636363626363636263636362636363) begin
            bad++;
            $display("FAIL zero_round1: valid=%b key=%h exp 1 62636363626363636263636362636363",
                     rd_valid, rd_key);
        end
        read_round(4'd10);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            bad++;
            $display("FAIL zero_round10: valid=%b key=%h exp 1 b4ef5bcb3e92e21123e951cf6f8f188e",
                     rd_valid, rd_key);
        end
    endtask

    task automatic test_read_errors();
        logic [127:0] key;
        int waited;
        key = {$urandom, $urandom, $urandom, $urandom};
        compute_model(key);
        accept_key(key);
        tick();
        read_round(4'd3);
        total++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            bad++;
            $display("FAIL read_in_expand: err=%b valid=%b key=%h exp 1 0 0", rd_err, rd_valid, rd_key);
        end
        key_in    = ~key;
        key_valid = 1'b1;
        #1;
        total++;
        if (key_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_expand: ready=%b exp 0", key_ready);
        end
        tick();
        key_valid = 1'b0;
        total++;
        if (rd_err !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width: err=%b valid=%b exp 0 0", rd_err, rd_valid);
        end
        waited = 0;
        while (keys_valid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        total++;
        if (keys_valid !== 1'b1) begin
            bad++;
            $display("FAIL kv_timeout: kv=%b exp 1", keys_valid);
        end
        read_round(4'd10);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== model_rk[10]) begin
            bad++;
            $display("FAIL ignored_key_round10: valid=%b key=%h exp 1 %h", rd_valid, rd_key, model_rk[10]);
        end
        read_round(4'd11);
        total++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            bad++;
            $display("FAIL read_r11: err=%b valid=%b key=%h exp 1 0 0", rd_err, rd_valid, rd_key);
        end
        read_round(4'd15);
        total++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            bad++;
            $display("FAIL read_r15: err=%b valid=%b key=%h exp 1 0 0", rd_err, rd_valid, rd_key);
        end
    endtask

    task automatic test_read_and_rekey();
        logic [127:0] key_a, key_b, old_r10;
        int cnt;
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        compute_model(key_a);
        old_r10 = model_rk[10];
        accept_key(key_a);
        for (int cyc = 1; cyc <= 10; cyc++) tick();
        rd_en     = 1'b1;
        rd_round  = 4'd10;
        key_in    = key_b;
        key_valid = 1'b1;
        tick();
        rd_en     = 1'b0;
        key_valid = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_key !== old_r10 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL rekey_read_old: valid=%b kv=%b key=%h exp 1 0 %h",
                     rd_valid, keys_valid, rd_key, old_r10);
        end
        read_round(4'd0);
        total++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rekey_next_read: err=%b valid=%b exp 1 0", rd_err, rd_valid);
        end
        cnt = 1;
        while (keys_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt !== 10) begin
            bad++;
            $display("FAIL rekey_latency: edges=%0d exp 10", cnt);
        end
        compute_model(key_b);
        for (int r = 0; r <= 10; r++) begin
            read_round(4'(r));
            total++;
            if (rd_valid !== 1'b1 || rd_key !== model_rk[r]) begin
                bad++;
                $display("FAIL rekey_new r=%0d: valid=%b key=%h exp 1 %h", r, rd_valid, rd_key, model_rk[r]);
            end
        end
    endtask

    task automatic test_reset_mid_expand();
        logic [127:0] key;
        int cnt;
        accept_key({$urandom, $urandom, $urandom, $urandom});
        for (int cyc = 1; cyc <= 4; cyc++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({key_ready, busy, keys_valid, rd_valid, rd_err} !== 5'b10000 || rd_key !== 128'h0) begin
            bad++;
            $display("FAIL mid_reset: ready/busy/kv/rv/re=%b rd_key=%h exp 10000 and 0",
                     {key_ready, busy, keys_valid, rd_valid, rd_err}, rd_key);
        end
        for (int i = 0; i < 3; i++) begin
            read_round(4'(i * 4));
            total++;
            if (rd_err !== 1'b1 || rd_valid !== 1'b0 || keys_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_read i=%0d: err=%b valid=%b kv=%b exp 1 0 0",
                         i, rd_err, rd_valid, keys_valid);
            end
        end
        key = {$urandom, $urandom, $urandom, $urandom};
        compute_model(key);
        accept_key(key);
        cnt = 0;
        while (keys_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt !== 10) begin
            bad++;
            $display("FAIL fresh_latency: edges=%0d exp 10", cnt);
        end
        read_round(4'd5);
        total++;
        if (rd_valid !== 1'b1 || rd_key !== model_rk[5]) begin
            bad++;
            $display("FAIL fresh_round5: valid=%b key=%h exp 1 %h", rd_valid, rd_key, model_rk[5]);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic [127:0] key;
            key = {$urandom, $urandom, $urandom, $urandom};
            compute_model(key);
            accept_key(key);
            for (int cyc = 1; cyc <= 10; cyc++) tick();
            rd_en = 1'b1;
            for (int r = 0; r <= 10; r++) begin
                rd_round = 4'(r);
                tick();
                total++;
                if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== model_rk[r]) begin
                    bad++;
                    $display("FAIL b2b k=%0d r=%0d: valid=%b err=%b key=%h exp 1 0 %h",
                             k, r, rd_valid, rd_err, rd_key, model_rk[r]);
                end
            end
            rd_en = 1'b0;
            tick();
            total++;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_end k=%0d: valid=%b exp 0", k, rd_valid);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        rd_round  = 4'd0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_read_errors();
        test_read_and_rekey();
        test_reset_mid_expand();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
